frv_pipeline_skid_buffer: RTL and testbench

- Buffered-handshake pipeline stage register: the receiving end of the stage-N to stage-N+1 valid/busy handshake.
- Decouples the stage-N busy path from the stage-N+1 busy path by registering o_busy. It does this with a two-entry (main + skid) buffer.
- Drop-in where a plain stage register would otherwise create a long combinational busy chain across the pipeline.
- Data ordering is strictly FIFO; no data is lost or duplicated.

---
 rtl/frv_pipeline_skid_buffer_if.sv | 24 ++
 rtl/frv_pipeline_skid_buffer.sv | 108 ++++++++++
 tb/tb_frv_pipeline_skid_buffer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/frv_pipeline_skid_buffer_if.sv
// Valid/busy handshake bundle for frv_pipeline_skid_buffer.
// The slave modport is the buffer itself; master is whatever surrounds it
// (stage N on the input side, stage N+1 on the output side).
interface frv_pipeline_skid_buffer_if #(
  parameter int unsigned RLEN = 8
) ();
  logic [RLEN-1:0] i_data;
  logic            i_valid;
  logic            o_busy;
  logic            flush;
  logic [RLEN-1:0] o_data;
  logic            o_valid;
  logic            i_busy;

  modport slave (
    input  i_data, i_valid, flush, i_busy,
    output o_busy, o_data, o_valid
  );

  modport master (
    output i_data, i_valid, flush, i_busy,
    input  o_busy, o_data, o_valid
  );
endinterface

// File: rtl/frv_pipeline_skid_buffer.sv
// Two-entry (main + skid) pipeline stage register with a registered o_busy,
// breaking the combinational busy chain between adjacent stages.
// Optional feature macro: FRV_PIPE_SKID_STALLCNT_EN adds a 32-bit stall_count
// output counting cycles with o_valid && i_busy.
module frv_pipeline_skid_buffer #(
  parameter int unsigned RLEN = 8
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
`ifdef FRV_PIPE_SKID_STALLCNT_EN
  output logic [31:0]              stall_count,
`endif
  frv_pipeline_skid_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [RLEN-1:0] r_main;
  logic [RLEN-1:0] w_main_nxt;
  logic [RLEN-1:0] r_skid;
  logic [RLEN-1:0] w_skid_nxt;
  logic            r_busy;
  logic            w_accept;
  logic            w_issue;
  logic            w_valid;

  assign w_valid  = (r_state != StEmpty);
  // r_busy mirrors (state == FULL) so o_busy never sees i_busy/i_valid combinationally.
  assign w_accept = bus.i_valid && !r_busy;
  assign w_issue  = w_valid && !bus.i_busy;

  assign bus.o_valid = w_valid;
  assign bus.o_busy  = r_busy;
  assign bus.o_data  = r_main;

  // Next-state and data-register selection; flush overrides every transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      StEmpty: begin
        if (w_accept) begin
          w_state_nxt = StOne;
          w_main_nxt  = bus.i_data;
        end
      end
      StOne: begin
        if (w_accept && w_issue) begin
          w_main_nxt = bus.i_data;
        end else if (w_accept) begin
          w_state_nxt = StFull;
          w_skid_nxt  = bus.i_data;
        end else if (w_issue) begin
          w_state_nxt = StEmpty;
        end
      end
      StFull: begin
        if (w_issue) begin
          w_state_nxt = StOne;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
    // Data registers are deliberately left alone on flush.
    if (bus.flush) begin
      w_state_nxt = StEmpty;
    end
  end

  // State, data and busy registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= StEmpty;
      r_main  <= '0;
      r_skid  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_busy  <= (w_state_nxt == StFull);
    end
  end

`ifdef FRV_PIPE_SKID_STALLCNT_EN
  logic [31:0] r_stall_cnt;

  assign stall_count = r_stall_cnt;

  // Stall counter: wraps naturally, untouched by flush.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_stall_cnt <= '0;
    end else if (w_valid && bus.i_busy) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frv_pipeline_skid_buffer.sv
// Self-checking bench for frv_pipeline_skid_buffer: a queue-based model of a
// two-deep FIFO stage checked every cycle, plus literal expectations.
module tb_frv_pipeline_skid_buffer;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;

  frv_pipeline_skid_buffer_if #(.RLEN(8)) bus ();

`ifdef FRV_PIPE_SKID_STALLCNT_EN
  logic [31:0] stall_count;
`endif

  frv_pipeline_skid_buffer #(.RLEN(8)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
`ifdef FRV_PIPE_SKID_STALLCNT_EN
    .stall_count(stall_count),
`endif
    .bus        (bus)
  );

  always #5 g_clk = ~g_clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: the stage is a FIFO of capacity two.
  logic [7:0]  mq[$];
  logic [7:0]  m_last = 8'h00;
  logic [31:0] m_stall = 32'd0;
  logic [7:0]  issued[$];
  bit          m_acc;
  bit          m_iss;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update plus log of words the DUT actually handed to stage N+1.
  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mq.delete();
      m_last  = 8'h00;
      m_stall = 32'd0;
    end else begin
      if (bus.o_valid && !bus.i_busy) issued.push_back(bus.o_data);
      m_acc = bus.i_valid && (mq.size() < 2);
      m_iss = (mq.size() > 0) && !bus.i_busy;
      if ((mq.size() > 0) && bus.i_busy) m_stall = m_stall + 32'd1;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (m_iss) void'(mq.pop_front());
        if (m_acc) mq.push_back(bus.i_data);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge g_clk) begin
    chk("o_valid", {31'd0, bus.o_valid}, {31'd0, mq.size() > 0});
    chk("o_busy", {31'd0, bus.o_busy}, {31'd0, mq.size() == 2});
    if (mq.size() > 0) chk("o_data", {24'd0, bus.o_data}, {24'd0, mq[0]});
    else if (!g_resetn) chk("o_data_rst", {24'd0, bus.o_data}, 32'd0);
`ifdef FRV_PIPE_SKID_STALLCNT_EN
    chk("stall_count", stall_count, m_stall);
`endif
  end

  task automatic step(input logic v, input logic [7:0] d, input logic b, input logic f);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_busy  = b;
    bus.flush   = f;
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic bz, input logic [7:0] d);
    chk({name, ".valid"}, {31'd0, bus.o_valid}, {31'd0, v});
    chk({name, ".busy"}, {31'd0, bus.o_busy}, {31'd0, bz});
    if (v) chk({name, ".data"}, {24'd0, bus.o_data}, {24'd0, d});
  endtask

  logic [7:0] exp_log[7];
  logic [7:0] cur_d;
  logic       cur_v;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = 8'h00;
    bus.i_busy  = 1'b0;
    bus.flush   = 1'b0;
    #2;
    chk("reset.valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset.busy", {31'd0, bus.o_busy}, 32'd0);
    chk("reset.data", {24'd0, bus.o_data}, 32'd0);
    @(posedge g_clk);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    // Streaming at full rate.
    step(1'b1, 8'h01, 1'b0, 1'b0); chk_out("stream1", 1'b1, 1'b0, 8'h01);
    step(1'b1, 8'h02, 1'b0, 1'b0); chk_out("stream2", 1'b1, 1'b0, 8'h02);
    step(1'b1, 8'h03, 1'b0, 1'b0); chk_out("stream3", 1'b1, 1'b0, 8'h03);
    step(1'b0, 8'h00, 1'b0, 1'b0); chk_out("stream_end", 1'b0, 1'b0, 8'h00);

    // Fill to FULL, hold A3 against busy, then drain in order.
    step(1'b1, 8'hA1, 1'b1, 1'b0); chk_out("fill1", 1'b1, 1'b0, 8'hA1);
    step(1'b1, 8'hA2, 1'b1, 1'b0); chk_out("fill2", 1'b1, 1'b1, 8'hA1);
    repeat (5) begin
      step(1'b1, 8'hA3, 1'b1, 1'b0); chk_out("full_hold", 1'b1, 1'b1, 8'hA1);
    end
    step(1'b1, 8'hA3, 1'b0, 1'b0); chk_out("drain1", 1'b1, 1'b0, 8'hA2);
    step(1'b1, 8'hA3, 1'b0, 1'b0); chk_out("drain2", 1'b1, 1'b0, 8'hA3);
    step(1'b0, 8'h00, 1'b0, 1'b0); chk_out("drain3", 1'b0, 1'b0, 8'h00);

    // Flush while FULL discards everything, including the word on i_data.
    step(1'b1, 8'hB1, 1'b1, 1'b0);
    step(1'b1, 8'hB2, 1'b1, 1'b0); chk_out("flush_pre", 1'b1, 1'b1, 8'hB1);
    step(1'b1, 8'hB3, 1'b1, 1'b1); chk_out("flush", 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0); chk_out("flush_after", 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-cycle while FULL.
    step(1'b1, 8'hC1, 1'b1, 1'b0);
    step(1'b1, 8'hC2, 1'b1, 1'b0); chk_out("rst_pre", 1'b1, 1'b1, 8'hC1);
    bus.i_valid = 1'b0;
    #2;
    g_resetn = 1'b0;
    #1;
    chk("async_rst.valid", {31'd0, bus.o_valid}, 32'd0);
    chk("async_rst.busy", {31'd0, bus.o_busy}, 32'd0);
    chk("async_rst.data", {24'd0, bus.o_data}, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    step(1'b1, 8'hD1, 1'b0, 1'b0); chk_out("post_rst", 1'b1, 1'b0, 8'hD1);
    step(1'b0, 8'h00, 1'b0, 1'b0); chk_out("post_rst_end", 1'b0, 1'b0, 8'h00);

    exp_log = '{8'h01, 8'h02, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hD1};
    chk("issued_count", issued.size(), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < issued.size()) chk("issued_word", {24'd0, issued[i]}, {24'd0, exp_log[i]});
    end

    // Mixed traffic: stage N holds its word while the model says busy.
    cur_v = 1'b0;
    cur_d = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (mq.size() < 2) begin
        cur_v = (i % 3) != 2;
        cur_d = 8'h40 + 8'(i);
      end
      step(cur_v, cur_d, ((i / 2) % 3) == 0, i == 21);
    end
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef FRV_PIPE_SKID_STALLCNT_EN
    g_resetn = 1'b0;
    #1;
    chk("stall_rst", stall_count, 32'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    step(1'b1, 8'hE1, 1'b1, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stall_seven", stall_count, 32'd7);
    #1;
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    m_stall = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stall_wrap", stall_count, 32'd0);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    @(negedge g_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
